fpu_add_sequencer: RTL

FPU_ADD_SEQUENCER -- requirements
Module: fpu_add_sequencer

---
 rtl/fpu_add_sequencer.sv | 69 ++++++
 1 files changed

// File: rtl/fpu_add_sequencer.sv
// fpu_add_sequencer: registers operands for an external combinational FP adder, captures its result and tracks sticky flags and completed operations.
module fpu_add_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_round,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic [1:0]       add_round,
  input  logic [31:0]      add_result,
  input  logic             add_error,
  input  logic             add_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_error,
  output logic             out_overflow,
  input  logic             clear_sticky,
  output logic             sticky_error,
  output logic             sticky_overflow,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nxt;
  logic accept, capture, handshake;
  always_comb begin
    out_valid = state == DONE;
    handshake = out_valid & out_ready;
    in_ready = (state == IDLE) | handshake;
    accept = in_valid & in_ready;
    capture = state == EXEC;
    state_nxt = accept ? EXEC : capture ? DONE : handshake ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      add_a <= '0;
      add_b <= '0;
      add_round <= '0;
      out_result <= '0;
      out_error <= 1'b0;
      out_overflow <= 1'b0;
      sticky_error <= 1'b0;
      sticky_overflow <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        add_a <= in_a;
        add_b <= in_b;
        add_round <= in_round;
      end
      if (capture) begin
        out_result <= add_result;
        out_error <= add_error;
        out_overflow <= add_overflow;
      end
      // a flag raised on the capture edge beats a simultaneous clear
      sticky_error <= (capture & add_error) | (sticky_error & ~clear_sticky);
      sticky_overflow <= (capture & add_overflow) | (sticky_overflow & ~clear_sticky);
      op_count <= op_count + CNT_W'(handshake & ~&op_count);
    end
  end
endmodule
